// File: rtl/burn_pkg.sv
// Shared state encoding and default constants for the stage burn sequencer.
package burn_pkg;

    localparam int BURN_N       = 64;
    localparam int BURN_SCALE   = 1000;
    localparam int BURN_GRAVITY = 9_799;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV_MDOT,
        ST_DIV_THR,
        ST_BURN,
        ST_END,
        ST_DONE,
        ST_FAULT
    } burn_state_t;

endpackage

// File: rtl/burn_sequencer_seq_divider.sv
// Restoring unsigned divider; the first step is taken on the start edge,
// so quotient/remainder are final N edges after start (done is high then).
module seq_divider #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N) + 1;

    logic [N-1:0]  rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  dsr_q;
    logic [CW-1:0] cnt_q;

    logic [N-1:0] src_rem;
    logic [N-1:0] src_quo;
    logic [N-1:0] src_dsr;
    logic [N:0]   trial;
    logic [N:0]   diff;
    logic [N-1:0] step_rem;
    logic [N-1:0] step_quo;

    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dsr = start ? divisor : dsr_q;
        trial   = {src_rem, src_quo[N-1]};
        diff    = trial - {1'b0, src_dsr};
        if (trial >= {1'b0, src_dsr}) begin
            step_rem = diff[N-1:0];
            step_quo = {src_quo[N-2:0], 1'b1};
        end else begin
            step_rem = trial[N-1:0];
            step_quo = {src_quo[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            dsr_q <= divisor;
            cnt_q <= CW'(N - 1);
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/burn_sequencer.sv
// Per-stage burn sequencer: latches stage parameters, derives mass flow and
// thrust with one shared divider, then burns on a prescaled seconds timebase.
module burn_sequencer
    import burn_pkg::*;
#(
    parameter int N          = BURN_N,
    parameter int PERIOD     = 10,
    parameter int SCALE      = BURN_SCALE,
    parameter int GRAVITY    = BURN_GRAVITY,
    parameter int LAST_STAGE = 4
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [3:0]   stage,
    input  logic [N-1:0] specific_impulse,
    input  logic [N-1:0] initial_weight,
    input  logic [N-1:0] weight_propellant,
    input  logic [N-1:0] burntime,
    output logic         ignition_end,
    output logic         burning,
    output logic         mission_complete,
    output logic         fault,
    output logic [N-1:0] current_mass,
    output logic [N-1:0] mass_flow,
    output logic [N-1:0] thrust,
    output logic [N-1:0] burn_elapsed
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    burn_state_t state_q;
    burn_state_t state_d;

    logic [3:0]    stage_q;
    logic [3:0]    stage_inc;
    logic [N-1:0]  isp_q;
    logic [N-1:0]  burntime_q;
    logic [N-1:0]  rem_q;
    logic [PW-1:0] prescale_q;

    logic         load_bad;
    logic         tick;
    logic         last_tick;
    logic         div_fin;
    logic [N-1:0] elapsed_inc;
    logic [N-1:0] thr_dividend;

    logic         div_start;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic         div_busy;
    logic         div_done;
    logic [N-1:0] div_quotient;
    logic [N-1:0] div_remainder;

    seq_divider #(
        .N(N)
    ) u_div (
        .clk       (clk),
        .resetb    (resetb),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign stage_inc    = stage_q + 4'd1;
    assign load_bad     = (burntime == '0) || (weight_propellant > initial_weight);
    assign elapsed_inc  = burn_elapsed + N'(1);
    assign tick         = (state_q == ST_BURN) && (prescale_q == PW'(PERIOD - 1));
    assign last_tick    = tick && (elapsed_inc == burntime_q);
    assign div_fin      = div_done && !div_busy;
    // Wraps at N bits; the quotient is the fresh mass flow in this cycle.
    assign thr_dividend = div_quotient * isp_q * N'(GRAVITY);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        div_dividend = weight_propellant;
        div_divisor  = burntime;
        unique case (state_q)
            ST_IDLE: begin
                if (stage != stage_q) begin
                    if (stage == 4'(LAST_STAGE + 1)) begin
                        state_d = ST_DONE;
                    end else if ((stage != stage_inc) || (stage == 4'd0)) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (load_bad) begin
                    state_d = ST_FAULT;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV_MDOT;
                end
            end
            ST_DIV_MDOT: begin
                if (div_fin) begin
                    div_start    = 1'b1;
                    div_dividend = thr_dividend;
                    div_divisor  = N'(SCALE);
                    state_d      = ST_DIV_THR;
                end
            end
            ST_DIV_THR: begin
                if (div_fin) begin
                    state_d = ST_BURN;
                end
            end
            ST_BURN: begin
                if (last_tick) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            ST_DONE, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            stage_q      <= '0;
            isp_q        <= '0;
            burntime_q   <= '0;
            rem_q        <= '0;
            prescale_q   <= '0;
            current_mass <= '0;
            mass_flow    <= '0;
            thrust       <= '0;
            burn_elapsed <= '0;
        end else begin
            if ((state_q == ST_IDLE) && (stage != stage_q)) begin
                stage_q <= stage;
            end
            if (state_q == ST_LOAD) begin
                isp_q      <= specific_impulse;
                burntime_q <= burntime;
                if (!load_bad) begin
                    current_mass <= initial_weight;
                    burn_elapsed <= '0;
                end
            end
            if ((state_q == ST_DIV_MDOT) && div_fin) begin
                mass_flow <= div_quotient;
                rem_q     <= div_remainder;
            end
            if ((state_q == ST_DIV_THR) && div_fin) begin
                thrust     <= div_quotient;
                prescale_q <= '0;
            end
            if (state_q == ST_BURN) begin
                prescale_q <= tick ? '0 : prescale_q + PW'(1);
            end
            // The last tick also drains the division remainder.
            if (tick) begin
                burn_elapsed <= elapsed_inc;
                current_mass <= current_mass - mass_flow - (last_tick ? rem_q : '0);
            end
        end
    end

    assign burning          = (state_q == ST_BURN);
    assign ignition_end     = (state_q == ST_END);
    assign mission_complete = (state_q == ST_DONE);
    assign fault            = (state_q == ST_FAULT);

endmodule

// File: tb/tb_burn_sequencer.sv
// Directed bench for burn_sequencer with hand-computed expectations.
module tb_burn_sequencer;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         resetb;
    logic [3:0]   stage;
    logic [N-1:0] isp;
    logic [N-1:0] init_w;
    logic [N-1:0] prop_w;
    logic [N-1:0] btime;
    logic         ignition_end;
    logic         burning;
    logic         mission_complete;
    logic         fault;
    logic [N-1:0] current_mass;
    logic [N-1:0] mass_flow;
    logic [N-1:0] thrust;
    logic [N-1:0] burn_elapsed;

    int n_checks  = 0;
    int n_errors  = 0;
    int ign_count = 0;

    burn_sequencer #(
        .N(N),
        .PERIOD(10),
        .SCALE(1000),
        .GRAVITY(9_799),
        .LAST_STAGE(4)
    ) dut (
        .clk               (clk),
        .resetb            (resetb),
        .stage             (stage),
        .specific_impulse  (isp),
        .initial_weight    (init_w),
        .weight_propellant (prop_w),
        .burntime          (btime),
        .ignition_end      (ignition_end),
        .burning           (burning),
        .mission_complete  (mission_complete),
        .fault             (fault),
        .current_mass      (current_mass),
        .mass_flow         (mass_flow),
        .thrust            (thrust),
        .burn_elapsed      (burn_elapsed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ignition_end) ign_count++;
    end

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        stage  = 4'd0;
        step(1);
        resetb = 1'b1;
    endtask

    // Leaves the caller exactly at the LOAD edge.
    task automatic start_stage(input logic [3:0] s, input logic [N-1:0] i,
                               input logic [N-1:0] iw, input logic [N-1:0] pw,
                               input logic [N-1:0] bt);
        stage  = s;
        isp    = i;
        init_w = iw;
        prop_w = pw;
        btime  = bt;
        @(posedge clk);
    endtask

    task automatic wait_burning(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!burning && n < 1000);
    endtask

    task automatic wait_ign(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!ignition_end && n < 5000);
    endtask

    task automatic wait_elapsed(input logic [N-1:0] target, output int n);
        n = 0;
        while (burn_elapsed != target && n < 3000) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int ign0;

        resetb = 1'b0;
        stage  = 4'd0;
        isp    = '0;
        init_w = '0;
        prop_w = '0;
        btime  = '0;
        step(2);
        check("rst_burning", burning, 0);
        check("rst_ign", ignition_end, 0);
        check("rst_fault", fault, 0);
        check("rst_mc", mission_complete, 0);
        check("rst_mass", current_mass, 0);
        check("rst_thrust", thrust, 0);
        resetb = 1'b1;
        step(1);

        // Stage 1; stage manager moves to 2 mid-burn.
        ign0 = ign_count;
        start_stage(4'd1, 263, 2875403, 2077000, 168);
        wait_burning(n);
        check("s1_latency", n, 129);
        check("s1_mdot", mass_flow, 12363);
        check("s1_thrust", thrust, 31861144);
        check("s1_elapsed0", burn_elapsed, 0);
        check("s1_mass0", current_mass, 2875403);
        step(100);
        stage  = 4'd2;
        isp    = 300;
        init_w = 500000;
        prop_w = 1000;
        btime  = 4;
        wait_ign(n);
        check("s1_burn_len", n + 100, 1680);
        check("s1_mass", current_mass, 798403);
        check("s1_elapsed", burn_elapsed, 168);
        check("s1_mdot_hold", mass_flow, 12363);
        check("s1_burning_end", burning, 0);

        // Stage 2 is picked up on return to WAIT.
        wait_burning(n);
        check("s2_latency", n, 131);
        check("s1_ign_once", ign_count - ign0, 1);
        check("s2_mdot", mass_flow, 250);
        check("s2_thrust", thrust, 734925);
        wait_ign(n);
        check("s2_burn_len", n, 40);
        check("s2_mass", current_mass, 499000);

        // Stage 3: remainder drained on the last tick.
        step(1);
        start_stage(4'd3, 250, 100000, 39136, 165);
        wait_burning(n);
        check("s3_latency", n, 129);
        check("s3_mdot", mass_flow, 237);
        check("s3_thrust", thrust, 580590);
        wait_elapsed(164, n);
        check("s3_elapsed164", burn_elapsed, 164);
        check("s3_mass164", current_mass, 61132);
        wait_ign(n);
        check("s3_mass", current_mass, 60864);
        check("s3_elapsed", burn_elapsed, 165);

        // Stage 4 then mission complete.
        step(1);
        start_stage(4'd4, 200, 10000, 100, 2);
        wait_burning(n);
        check("s4_thrust", thrust, 97990);
        wait_ign(n);
        check("s4_mass", current_mass, 9900);
        step(1);
        ign0  = ign_count;
        stage = 4'd5;
        step(1);
        check("done_mc", mission_complete, 1);
        check("done_fault", fault, 0);
        stage = 4'd6;
        step(200);
        check("done_mc_hold", mission_complete, 1);
        check("done_no_burn", burning, 0);
        check("done_no_ign", ign_count - ign0, 0);
        check("done_fault_hold", fault, 0);

        // Zero burn time faults.
        do_reset();
        ign0 = ign_count;
        start_stage(4'd1, 263, 1000, 100, 0);
        step(2);
        check("bt0_fault", fault, 1);
        step(200);
        check("bt0_burning", burning, 0);
        check("bt0_no_ign", ign_count - ign0, 0);

        // Propellant heavier than the stack faults.
        do_reset();
        start_stage(4'd1, 263, 1000, 2000, 5);
        step(2);
        check("prop_fault", fault, 1);
        check("prop_burning", burning, 0);

        // Stage jump 1 -> 3 from WAIT faults.
        do_reset();
        start_stage(4'd1, 100, 1000, 100, 2);
        wait_ign(n);
        check("jump_s1_mass", current_mass, 900);
        check("jump_pre_fault", fault, 0);
        step(1);
        stage = 4'd3;
        step(1);
        check("jump_fault", fault, 1);
        check("jump_mc", mission_complete, 0);

        // Reset mid-burn, then a full restart.
        do_reset();
        start_stage(4'd1, 263, 2875403, 2077000, 168);
        wait_burning(n);
        wait_elapsed(50, n);
        check("mid_elapsed50", burn_elapsed, 50);
        ign0   = ign_count;
        resetb = 1'b0;
        stage  = 4'd0;
        step(1);
        check("mid_rst_burning", burning, 0);
        check("mid_rst_mass", current_mass, 0);
        check("mid_rst_elapsed", burn_elapsed, 0);
        check("mid_rst_mdot", mass_flow, 0);
        check("mid_rst_thrust", thrust, 0);
        resetb = 1'b1;
        step(1);
        check("mid_rst_no_ign", ign_count - ign0, 0);
        start_stage(4'd1, 263, 2875403, 2077000, 168);
        wait_burning(n);
        check("re_latency", n, 129);
        check("re_elapsed0", burn_elapsed, 0);
        wait_ign(n);
        check("re_burn_len", n, 1680);
        check("re_mass", current_mass, 798403);
        check("re_elapsed", burn_elapsed, 168);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
